// File: rtl/error_convert_arbiter.sv
// Round-robin front end that shares one fixed-latency nm->mm conversion pipeline among NREQ sources.
// Define ERR_CONVERT_ARB_PRIORITY0_EN to give requester 0 strict priority over the round-robin group.
module error_convert_arbiter #(
  parameter int NREQ         = 4,
  parameter int PIPE_LATENCY = 12,
  parameter int TAG_W        = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 clearErrors,
  input  logic [NREQ-1:0]      reqValid,
  input  logic [NREQ*32-1:0]   reqData,
  output logic [NREQ-1:0]      reqReady,
  output logic                 convValid,
  output logic [31:0]          convData,
  input  logic                 convResultValid,
  input  logic [63:0]          convResult,
  output logic [NREQ-1:0]      rspValid,
  output logic [63:0]          rspData,
  output logic [TAG_W-1:0]     rspTag,
  output logic                 busy,
  output logic [31:0]          status
);

`ifdef ERR_CONVERT_ARB_PRIORITY0_EN
  localparam logic [TAG_W-1:0] PTR_INIT = TAG_W'(1);
`else
  localparam logic [TAG_W-1:0] PTR_INIT = '0;
`endif

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] nextPtr;
  logic [TAG_W-1:0] grantIdx;
  logic [TAG_W-1:0] cand;
  logic             grantAny;
  logic [31:0]      grantData;

  // Stage 0 sits beside convValid; stage PIPE_LATENCY lines up with convResultValid.
  logic             pipeValid [0:PIPE_LATENCY];
  logic [TAG_W-1:0] pipeTag   [0:PIPE_LATENCY];
  logic             exitValid;
  logic [TAG_W-1:0] exitTag;

  logic [7:0]       inFlight;
  logic             orphanErr;
  logic             missingErr;

  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    cand     = '0;
    if (enable && resetN) begin
`ifdef ERR_CONVERT_ARB_PRIORITY0_EN
      if (reqValid[0]) begin
        grantAny = 1'b1;
      end else begin
        for (int k = 0; k < NREQ - 1; k++) begin
          cand = TAG_W'(1 + ((int'(ptr) - 1 + k) % (NREQ - 1)));
          if (!grantAny && reqValid[cand]) begin
            grantAny = 1'b1;
            grantIdx = cand;
          end
        end
      end
`else
      for (int k = 0; k < NREQ; k++) begin
        cand = TAG_W'((int'(ptr) + k) % NREQ);
        if (!grantAny && reqValid[cand]) begin
          grantAny = 1'b1;
          grantIdx = cand;
        end
      end
`endif
    end
  end

  always_comb begin
    nextPtr = ptr;
`ifdef ERR_CONVERT_ARB_PRIORITY0_EN
    // Grants to requester 0 leave the round-robin position untouched.
    if (grantAny && grantIdx != '0)
      nextPtr = (int'(grantIdx) == NREQ - 1) ? TAG_W'(1) : grantIdx + TAG_W'(1);
`else
    if (grantAny)
      nextPtr = (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + TAG_W'(1);
`endif
  end

  always_comb begin
    grantData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantIdx == TAG_W'(i))
        grantData = reqData[i*32 +: 32];
    end
  end

  assign reqReady  = grantAny ? (NREQ'(1) << grantIdx) : '0;
  assign exitValid = pipeValid[PIPE_LATENCY];
  assign exitTag   = pipeTag[PIPE_LATENCY];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ptr       <= PTR_INIT;
      convValid <= 1'b0;
      convData  <= '0;
    end else begin
      ptr       <= nextPtr;
      convValid <= grantAny;
      if (grantAny)
        convData <= grantData;
    end
  end

  // The conversion chain never stalls, so the tag pipe shifts every cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i <= PIPE_LATENCY; i++) begin
        pipeValid[i] <= 1'b0;
        pipeTag[i]   <= '0;
      end
    end else begin
      pipeValid[0] <= grantAny;
      pipeTag[0]   <= grantIdx;
      for (int i = 1; i <= PIPE_LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeTag[i]   <= pipeTag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rspValid <= '0;
      rspData  <= '0;
      rspTag   <= '0;
    end else if (exitValid && convResultValid) begin
      rspValid <= NREQ'(1) << exitTag;
      rspData  <= convResult;
      rspTag   <= exitTag;
    end else begin
      rspValid <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inFlight <= '0;
    end else if (grantAny && !exitValid && inFlight != 8'hFF) begin
      inFlight <= inFlight + 8'd1;
    end else if (!grantAny && exitValid && inFlight != 8'h00) begin
      inFlight <= inFlight - 8'd1;
    end
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      orphanErr  <= 1'b0;
      missingErr <= 1'b0;
    end else begin
      if (convResultValid && !exitValid)
        orphanErr <= 1'b1;
      else if (clearErrors)
        orphanErr <= 1'b0;
      if (exitValid && !convResultValid)
        missingErr <= 1'b1;
      else if (clearErrors)
        missingErr <= 1'b0;
    end
  end

  assign busy   = (inFlight != 8'h00) | convValid;
  assign status = {16'h0000, orphanErr, missingErr, 6'h00, inFlight};

endmodule

// File: tb/tb_error_convert_arbiter.sv
// Bench for error_convert_arbiter: emulates the conversion pipeline and checks every cycle
// against a cycle-keyed model of grants, returns, error flags and the in-flight count.
module tb_error_convert_arbiter;
  localparam int NREQ         = 4;
  localparam int PIPE_LATENCY = 12;
  localparam int TAG_W        = 2;

  logic                clk = 1'b0;
  logic                resetN;
  logic                enable;
  logic                clearErrors;
  logic [NREQ-1:0]     reqValid;
  logic [NREQ*32-1:0]  reqData;
  logic [NREQ-1:0]     reqReady;
  logic                convValid;
  logic [31:0]         convData;
  logic                convResultValid;
  logic [63:0]         convResult;
  logic [NREQ-1:0]     rspValid;
  logic [63:0]         rspData;
  logic [TAG_W-1:0]    rspTag;
  logic                busy;
  logic [31:0]         status;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int              mPtr;
  logic            mConvValid;
  logic [31:0]     mConvData;
  logic [NREQ-1:0] mRspValid;
  logic [63:0]     mRspData;
  int              mRspTag;
  logic            mOrphan;
  logic            mMissing;
  int              mInFlight;
  int              exitTagAt [int];
  bit              schedV    [int];
  logic [63:0]     schedD    [int];
  bit              dropNext;

  error_convert_arbiter #(
    .NREQ(NREQ), .PIPE_LATENCY(PIPE_LATENCY), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .clearErrors(clearErrors),
    .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
    .convValid(convValid), .convData(convData),
    .convResultValid(convResultValid), .convResult(convResult),
    .rspValid(rspValid), .rspData(rspData), .rspTag(rspTag),
    .busy(busy), .status(status)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", name, observed, expected, cyc);
    end
  endtask

  task automatic modelReset();
    mPtr       = 0;
    mConvValid = 1'b0;
    mConvData  = '0;
    mRspValid  = '0;
    mRspData   = '0;
    mRspTag    = 0;
    mOrphan    = 1'b0;
    mMissing   = 1'b0;
    mInFlight  = 0;
    exitTagAt.delete();
  endtask

  // One clock cycle: drive the pipeline return, check the grant, clock, update model, check outputs.
  task automatic applyStimulus();
    int          g;
    bit          ev;
    int          et;
    bit          rv;
    logic [63:0] rd;
    rv = schedV.exists(cyc);
    rd = rv ? schedD[cyc] : {$urandom, $urandom};
    convResultValid = rv;
    convResult      = rd;
    #1;
    g = -1;
    if (resetN && enable) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (mPtr + k) % NREQ;
        if (g < 0 && reqValid[i]) g = i;
      end
    end
    checkOutput("reqReady", 64'(reqReady), (g >= 0) ? (64'(1) << g) : 64'(0));
    @(posedge clk);
    #1;
    if (!resetN) begin
      modelReset();
    end else begin
      ev = exitTagAt.exists(cyc);
      et = ev ? exitTagAt[cyc] : 0;
      if (ev) exitTagAt.delete(cyc);
      if (g >= 0) begin
        mPtr       = (g + 1) % NREQ;
        mConvValid = 1'b1;
        mConvData  = reqData[g*32 +: 32];
        exitTagAt[cyc + PIPE_LATENCY + 1] = g;
      end else begin
        mConvValid = 1'b0;
      end
      if (ev && rv) begin
        mRspValid = NREQ'(1) << et;
        mRspData  = rd;
        mRspTag   = et;
      end else begin
        mRspValid = '0;
      end
      if (rv && !ev) mOrphan = 1'b1;
      else if (clearErrors) mOrphan = 1'b0;
      if (ev && !rv) mMissing = 1'b1;
      else if (clearErrors) mMissing = 1'b0;
      mInFlight = mInFlight + ((g >= 0) ? 1 : 0) - (ev ? 1 : 0);
      if (mInFlight > 255) mInFlight = 255;
      if (mInFlight < 0) mInFlight = 0;
    end
    schedV.delete(cyc);
    schedD.delete(cyc);
    cyc++;
    if (convValid === 1'b1) begin
      if (dropNext) begin
        dropNext = 1'b0;
      end else begin
        schedV[cyc + PIPE_LATENCY] = 1'b1;
        schedD[cyc + PIPE_LATENCY] = (convData == 32'd1000) ? 64'h3FF0000000000000 : {$urandom, $urandom};
      end
    end
    checkOutput("convValid", 64'(convValid), 64'(mConvValid));
    checkOutput("convData", 64'(convData), 64'(mConvData));
    checkOutput("rspValid", 64'(rspValid), 64'(mRspValid));
    checkOutput("rspData", rspData, mRspData);
    checkOutput("rspTag", 64'(rspTag), 64'(mRspTag));
    checkOutput("busy", 64'(busy), 64'((mInFlight != 0) || mConvValid));
    checkOutput("status", 64'(status), 64'({16'h0000, mOrphan, mMissing, 6'h00, 8'(mInFlight)}));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic randomData();
    for (int i = 0; i < NREQ; i++) reqData[i*32 +: 32] = $urandom;
  endtask

  initial begin
    resetN          = 1'b0;
    enable          = 1'b0;
    clearErrors     = 1'b0;
    reqValid        = '0;
    reqData         = '0;
    convResultValid = 1'b0;
    convResult      = '0;
    dropNext        = 1'b0;
    modelReset();
    idle(2);

    $display("[TB] single word");
    resetN   = 1'b1;
    enable   = 1'b1;
    reqValid = 4'b0001;
    reqData[31:0] = 32'd1000;
    applyStimulus();
    reqValid = '0;
    idle(16);

    $display("[TB] fairness, all requesters streaming");
    reqValid = '1;
    for (int i = 0; i < 8; i++) begin
      randomData();
      applyStimulus();
    end
    reqValid = '0;
    idle(16);

    $display("[TB] orphan result and clear");
    schedV[cyc] = 1'b1;
    schedD[cyc] = {$urandom, $urandom};
    idle(3);
    clearErrors = 1'b1;
    applyStimulus();
    clearErrors = 1'b0;
    idle(2);

    $display("[TB] orphan coinciding with clear");
    schedV[cyc] = 1'b1;
    schedD[cyc] = {$urandom, $urandom};
    clearErrors = 1'b1;
    applyStimulus();
    clearErrors = 1'b0;
    idle(2);
    clearErrors = 1'b1;
    applyStimulus();
    clearErrors = 1'b0;

    $display("[TB] missing result");
    dropNext = 1'b1;
    reqValid = 4'b0010;
    randomData();
    applyStimulus();
    reqValid = '0;
    idle(16);
    clearErrors = 1'b1;
    applyStimulus();
    clearErrors = 1'b0;

    $display("[TB] enable drop mid-stream");
    reqValid = '1;
    for (int i = 0; i < 20; i++) begin
      enable = (i < 3);
      randomData();
      applyStimulus();
    end
    reqValid = '0;
    enable   = 1'b1;
    idle(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      reqValid    = NREQ'($urandom);
      enable      = ($urandom_range(0, 7) != 0);
      clearErrors = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) dropNext = 1'b1;
      randomData();
      applyStimulus();
    end
    reqValid    = '0;
    enable      = 1'b1;
    clearErrors = 1'b0;
    dropNext    = 1'b0;
    idle(16);
    clearErrors = 1'b1;
    applyStimulus();
    clearErrors = 1'b0;

    $display("[TB] reset mid-flight");
    reqValid = '1;
    for (int i = 0; i < 5; i++) begin
      randomData();
      applyStimulus();
    end
    reqValid = '0;
    resetN   = 1'b0;
    idle(2);
    resetN   = 1'b1;
    idle(20);
    clearErrors = 1'b1;
    applyStimulus();
    clearErrors = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
